// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data) arbiter in front of a single
// memory with at most one outstanding transaction.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin on simultaneous
// requests); when undefined the data port has fixed priority.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    // instruction fetch port
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    // data port
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    // shared memory command / response
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int unsigned BE_W = DATA_W / 8;

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;

    state_t              state_q;
    owner_t              owner_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [BE_W-1:0]     mem_be_q;
    logic                if_rvalid_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic                d_rvalid_q;
    logic [DATA_W-1:0]   d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    owner_t              last_q;
`endif

    logic                grant_d;
    logic                pick_d_d;

    // Winner selection and combinational grant pulse (IDLE only, never both)
    always_comb begin
        pick_d_d = d_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (if_req && d_req) begin
            pick_d_d = (last_q == OWN_IF);
        end
`endif
        grant_d = !reset && (state_q == S_IDLE) && (if_req || d_req);
        if_gnt  = grant_d && !pick_d_d;
        d_gnt   = grant_d && pick_d_d;
    end

    // Transaction FSM: latch command on grant, route response to the owner
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q      <= OWN_IF;
`endif
        end else begin
            mem_req_q   <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if (state_q == S_IDLE) begin
                if (grant_d) begin
                    mem_req_q <= 1'b1;
                    state_q   <= S_WAIT;
`ifdef ARB_ROUND_ROBIN_EN
                    last_q    <= pick_d_d ? OWN_D : OWN_IF;
`endif
                    if (pick_d_d) begin
                        owner_q     <= OWN_D;
                        mem_we_q    <= d_we;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                        mem_be_q    <= d_be;
                    end else begin
                        owner_q     <= OWN_IF;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= '0;
                        mem_be_q    <= '1;
                    end
                end
            end else begin
                if (mem_rvalid) begin
                    state_q <= S_IDLE;
                    if (owner_q == OWN_D) begin
                        d_rvalid_q <= 1'b1;
                        // write acks leave read data untouched
                        if (!mem_we_q) begin
                            d_rdata_q <= mem_rdata;
                        end
                    end else begin
                        if_rvalid_q <= 1'b1;
                        if_rdata_q  <= mem_rdata;
                    end
                end
            end
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of all ports.
REQ-002 Parameter: DATA_W, 32, data width; byte-enable width is DATA_W/8.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset; ports are named clk and reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 if_req  in  1  instruction-fetch read request.
REQ-007 if_addr  in  ADDR_W  fetch address.
REQ-008 if_gnt  out  1  fetch request accepted (one-cycle pulse).
REQ-009 if_rvalid  out  1  fetch data valid (one-cycle pulse).
REQ-010 if_rdata  out  DATA_W  fetch read data.
REQ-011 d_req, d_we  in  1 each  data-port request, write enable.
REQ-012 d_addr  in  ADDR_W; d_wdata  in  DATA_W; d_be  in  DATA_W/8: data-port address, write data, byte enables.
REQ-013 d_gnt, d_rvalid  out  1 each; d_rdata  out  DATA_W: data-port grant, response pulse, read data.
REQ-014 mem_req, mem_we  out  1 each; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_be  out  DATA_W/8: shared memory command.
REQ-015 mem_rvalid  in  1; mem_rdata  in  DATA_W: memory response (reads and write acks), one or more cycles after mem_req.

Function
REQ-016 The block SHALL run FSM states IDLE and WAIT, with at most one outstanding memory transaction.
REQ-017 In IDLE with any request present, the block SHALL select one winner, assert its gnt combinationally that cycle, latch its command into the mem_* registers, set owner, pulse mem_req high for exactly one cycle starting next cycle, and go to WAIT.
REQ-018 Fetch grants SHALL drive mem_we=0 and mem_be=all ones.
REQ-019 In WAIT, gnt SHALL stay low; on mem_rvalid the block SHALL register mem_rdata into the owner's rdata, pulse the owner's rvalid the following cycle, and return to IDLE.
REQ-020 A new grant SHALL be possible in the cycle a rvalid pulse is asserted (back-to-back throughput: one transaction per 3 cycles at single-cycle memory latency).
REQ-021 x_rdata SHALL hold its last value until that port's next response; write acks SHALL pulse d_rvalid and leave d_rdata unchanged.
REQ-022 mem_rvalid received in IDLE SHALL be ignored.
REQ-023 Requesters hold req and command fields stable until gnt; a req dropped before gnt is not serviced.
REQ-024 gnt SHALL never be asserted to both ports in the same cycle.

Reset
REQ-025 On reset: state=IDLE, mem_req=0, mem_we=0, mem_addr/mem_wdata/mem_be=0, all gnt/rvalid=0, all rdata=0, owner=fetch, last-grant=fetch.
REQ-026 Reset during WAIT SHALL abandon the transaction; no rvalid for it SHALL be issued, and a stale mem_rvalid after reset SHALL be ignored.

Configuration
REQ-027 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests, the port not granted last wins (the last-grant register updates on every grant).
REQ-028 Macro ARB_ROUND_ROBIN_EN undefined: the data port always wins simultaneous requests (fixed priority), and the last-grant register is unused.

Verification
REQ-029 Single fetch: if_req=1, if_addr=0x10, memory returns 0x00500093 one cycle after mem_req -> if_gnt pulses once, mem_addr=0x10 with mem_we=0 and mem_be=0xF, then if_rvalid=1 with if_rdata=0x00500093.
REQ-030 Write: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=0x3 -> mem_we=1, mem_be=0x3, mem_wdata=0xDEADBEEF, then a d_rvalid pulse with d_rdata unchanged.
REQ-031 Both requests held for 4 transactions -> fixed priority: d,d,d,d; round-robin: alternating, starting with d (last-grant=fetch after reset).
REQ-032 Memory latency 5 cycles -> no gnt during WAIT; exactly one rvalid; mem_req is high for exactly one cycle.
REQ-033 Reset asserted during WAIT, then mem_rvalid arrives -> no rvalid on either port; all outputs are 0; the next request is serviced normally.
